// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: elastic pipeline for packed control words.
// STAGES register slots, each with its own valid bit. Slot 0 is the youngest
// and slot STAGES-1 drives the output. Valid/ready handshakes are used on both
// sides. Bubbles collapse toward the output, and a global flush kills every
// in-flight word. The per-slot taps feed the hazard/forwarding unit.
module ctrl_pipe_stage #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 3,
    localparam int CW    = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_ctrl,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_ctrl,
    output logic [CW-1:0]             count
);

    logic [STAGES-1:0]            v;
    logic [STAGES-1:0]            rdy;
    logic [STAGES-1:0]            v_in;
    logic [STAGES-1:0][WIDTH-1:0] d;
    logic [STAGES-1:0][WIDTH-1:0] d_in;
    logic                         in_fire;
    logic                         out_fire;

    // Ready chain in flattened form. Slot i can advance when out_ready is high,
    // or when some slot from i up to the output is empty. This expansion equals
    // rdy[i] = !v[i] | rdy[i+1], but it has no self-referencing bit chain.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < STAGES; i++) begin
            rdy[i] = out_ready | ((v >> i) != ({STAGES{1'b1}} >> i));
        end
    end

    assign in_ready  = rdy[0] & !flush;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = v[STAGES-1] & !flush;
    assign out_fire  = out_valid & out_ready;

    // Source of each slot. Slot 0 takes the upstream word.
    // Every other slot takes the word from the slot behind it.
    always_comb begin
        v_in    = '0;
        d_in    = '0;
        v_in[0] = in_fire;
        d_in[0] = in_ctrl;
        for (int i = 1; i < STAGES; i++) begin
            v_in[i] = v[i-1];
            d_in[i] = d[i-1];
        end
    end

    // Valid bits: a slot advances when ready, and flush empties every slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v[i] <= v_in[i];
                end
            end
        end
    end

    // Data registers load only real words.
    // On a bubble or a flush a slot keeps its stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d <= '0;
        end else if (!flush) begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i] && v_in[i]) begin
                    d[i] <= d_in[i];
                end
            end
        end
    end

    // Occupancy counter, kept equal to the number of set valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_fire) - CW'(out_fire);
        end
    end

    assign out_ctrl    = d[STAGES-1];
    assign stage_valid = v;
    assign stage_ctrl  = d;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// tb_ctrl_pipe_stage: directed scenarios plus a randomized run against a
// behavioural model. The model tracks each in-flight word as a position, not
// as RTL slot registers.
module tb_ctrl_pipe_stage;

    localparam int W = 12;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_ctrl = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_ctrl;
    logic [S-1:0]   stage_valid;
    logic [S*W-1:0] stage_ctrl;
    logic [1:0]     count;

    int n_vec  = 0;
    int n_fail = 0;

    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_ctrl = '0;

    ctrl_pipe_stage #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .stage_valid(stage_valid), .stage_ctrl(stage_ctrl), .count(count)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Upstream protocol: a word offered but not taken must stay unchanged.
    always @(posedge clk) begin
        if (!rst && hold_pend && in_valid) begin
            assert (in_ctrl == hold_ctrl) else $error("[TB] upstream changed in_ctrl while stalled");
        end
        hold_pend <= !rst && in_valid && !in_ready;
        hold_ctrl <= in_ctrl;
    end

    // Drive one cycle's inputs at the falling edge, then let them settle.
    task automatic drive(input logic f, input logic iv, input logic [W-1:0] ic, input logic ordy);
        @(negedge clk);
        flush     = f;
        in_valid  = iv;
        in_ctrl   = ic;
        out_ready = ordy;
        #1;
    endtask

    // Hold reset for two edges, then release it at a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 1, 12'h123, 0);
        drive(0, 1, 12'h456, 0);
        drive(0, 0, 12'h000, 0);
        n_vec++;
        if (count !== 2'd2) begin n_fail++; $display("[TB] FAIL rst_precount got %0d exp 2", count); end
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid got %b exp 0", out_valid); end
        n_vec++;
        if (stage_valid !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_stage_valid got %b exp 000", stage_valid); end
        n_vec++;
        if (count !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_count got %0d exp 0", count); end
        n_vec++;
        if (stage_ctrl !== 36'h0) begin n_fail++; $display("[TB] FAIL rst_stage_ctrl got %h exp 0", stage_ctrl); end
        n_vec++;
        if (out_ctrl !== 12'h0) begin n_fail++; $display("[TB] FAIL rst_out_ctrl got %h exp 0", out_ctrl); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; in_ctrl = 12'h5A5; out_ready = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready got %b exp 1", in_ready); end
        drive(0, 0, 12'h000, 0);
        n_vec++;
        if (count !== 2'd1) begin n_fail++; $display("[TB] FAIL rst_first_accept_count got %0d exp 1", count); end
        n_vec++;
        if (stage_valid !== 3'b001 || stage_ctrl[W-1:0] !== 12'h5A5) begin
            n_fail++; $display("[TB] FAIL rst_first_accept_slot got v=%b d=%h exp v=001 d=5a5", stage_valid, stage_ctrl[W-1:0]);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            if (k < 8) drive(0, 1, W'(k + 1), 1);
            else       drive(0, 0, 12'h000, 1);
            n_vec++;
            if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_in_ready cyc %0d got %b exp 1", k, in_ready); end
            if (k >= 3) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_ctrl !== W'(k - 2)) begin
                    n_fail++; $display("[TB] FAIL stream_out cyc %0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_ctrl, W'(k - 2));
                end
            end else begin
                n_vec++;
                if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_fill_out_valid cyc %0d got %b exp 0", k, out_valid); end
            end
            if (k <= 8) begin
                n_vec++;
                if (count !== ((k < 3) ? 2'(k) : 2'd3)) begin
                    n_fail++; $display("[TB] FAIL stream_count cyc %0d got %0d exp %0d", k, count, (k < 3) ? k : 3);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_words [3];
        exp_words[0] = 12'h0A1; exp_words[1] = 12'h0A2; exp_words[2] = 12'h0A3;
        do_reset();
        drive(0, 1, 12'h0A1, 0);
        drive(0, 1, 12'h0A2, 0);
        drive(0, 1, 12'h0A3, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 12'h000, 0);
            n_vec++;
            if (in_ready !== 1'b0 || count !== 2'd3) begin
                n_fail++; $display("[TB] FAIL bp_stall cyc %0d got rdy=%b cnt=%0d exp rdy=0 cnt=3", k, in_ready, count);
            end
            n_vec++;
            if (out_valid !== 1'b1 || out_ctrl !== 12'h0A1) begin
                n_fail++; $display("[TB] FAIL bp_hold_out cyc %0d got v=%b d=%h exp v=1 d=0a1", k, out_valid, out_ctrl);
            end
            n_vec++;
            if (stage_ctrl !== {12'h0A1, 12'h0A2, 12'h0A3}) begin
                n_fail++; $display("[TB] FAIL bp_slots cyc %0d got %h exp 0a10a20a3", k, stage_ctrl);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 12'h000, 1);
            n_vec++;
            if (k < 3) begin
                if (out_valid !== 1'b1 || out_ctrl !== exp_words[k]) begin
                    n_fail++; $display("[TB] FAIL bp_drain cyc %0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_ctrl, exp_words[k]);
                end
            end else if (out_valid !== 1'b0 || count !== 2'd0) begin
                n_fail++; $display("[TB] FAIL bp_drained got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count);
            end
        end
    endtask

    task automatic test_bubble_collapse();
        do_reset();
        drive(0, 1, 12'h111, 0);
        drive(0, 0, 12'h000, 0);
        drive(0, 1, 12'h222, 0);
        drive(0, 0, 12'h000, 0);
        drive(0, 0, 12'h000, 0);
        n_vec++;
        if (stage_valid !== 3'b110) begin n_fail++; $display("[TB] FAIL bubble_valid got %b exp 110", stage_valid); end
        n_vec++;
        if (stage_ctrl[2*W +: W] !== 12'h111 || stage_ctrl[W +: W] !== 12'h222) begin
            n_fail++; $display("[TB] FAIL bubble_data got s2=%h s1=%h exp s2=111 s1=222", stage_ctrl[2*W +: W], stage_ctrl[W +: W]);
        end
        n_vec++;
        if (in_ready !== 1'b1 || count !== 2'd2) begin
            n_fail++; $display("[TB] FAIL bubble_ready_count got rdy=%b cnt=%0d exp rdy=1 cnt=2", in_ready, count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(0, 1, 12'h301, 0);
        drive(0, 1, 12'h302, 0);
        drive(0, 1, 12'h303, 0);
        drive(1, 1, 12'h3FF, 1);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_cycle got ov=%b ir=%b exp ov=0 ir=0", out_valid, in_ready);
        end
        drive(0, 0, 12'h000, 1);
        n_vec++;
        if (stage_valid !== 3'b000 || count !== 2'd0) begin
            n_fail++; $display("[TB] FAIL flush_after got v=%b cnt=%0d exp v=000 cnt=0", stage_valid, count);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 12'h000, 1);
            n_vec++;
            if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_leak cyc %0d got ov=%b d=%h exp ov=0", k, out_valid, out_ctrl); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] qd[$];
        int           qp[$];
        logic [W-1:0] nd[$];
        int           np[$];
        logic         pend;
        logic [W-1:0] held;
        logic         f, iv, ordy, exp_ir, exp_ov, moved, prev_moved;
        logic [W-1:0] ic;
        logic [S-1:0] exp_sv;
        int           prev_pos;
        do_reset();
        pend = 1'b0;
        held = '0;
        for (int c = 0; c < 10000; c++) begin
            f = ($urandom_range(0, 99) < 4);
            if (pend) begin
                iv = 1'b1; ic = held;
            end else begin
                iv = ($urandom_range(0, 99) < 60);
                ic = W'($urandom_range(0, 4095));
            end
            ordy = ($urandom_range(0, 99) < 60);
            drive(f, iv, ic, ordy);

            exp_ir = !f && (qd.size() < S || ordy);
            exp_ov = !f && qd.size() > 0 && qp[0] == S - 1;
            exp_sv = '0;
            foreach (qp[k]) exp_sv[qp[k]] = 1'b1;

            n_vec++;
            if (in_ready !== exp_ir) begin n_fail++; $display("[TB] FAIL rnd_in_ready cyc %0d got %b exp %b", c, in_ready, exp_ir); end
            n_vec++;
            if (out_valid !== exp_ov) begin n_fail++; $display("[TB] FAIL rnd_out_valid cyc %0d got %b exp %b", c, out_valid, exp_ov); end
            if (exp_ov) begin
                n_vec++;
                if (out_ctrl !== qd[0]) begin n_fail++; $display("[TB] FAIL rnd_out_ctrl cyc %0d got %h exp %h", c, out_ctrl, qd[0]); end
            end
            n_vec++;
            if (stage_valid !== exp_sv) begin n_fail++; $display("[TB] FAIL rnd_stage_valid cyc %0d got %b exp %b", c, stage_valid, exp_sv); end
            n_vec++;
            if (count !== 2'(qd.size())) begin n_fail++; $display("[TB] FAIL rnd_count cyc %0d got %0d exp %0d", c, count, qd.size()); end
            n_vec++;
            if (32'(count) !== $countones(stage_valid)) begin
                n_fail++; $display("[TB] FAIL rnd_popcount cyc %0d got cnt=%0d exp %0d", c, count, $countones(stage_valid));
            end
            foreach (qp[k]) begin
                n_vec++;
                if (stage_ctrl[qp[k]*W +: W] !== qd[k]) begin
                    n_fail++; $display("[TB] FAIL rnd_stage_ctrl cyc %0d slot %0d got %h exp %h", c, qp[k], stage_ctrl[qp[k]*W +: W], qd[k]);
                end
            end

            // A word moves forward if the position ahead of it is free or is being vacated.
            if (f) begin
                qd.delete(); qp.delete();
            end else begin
                nd.delete(); np.delete();
                prev_pos = -1; prev_moved = 1'b0;
                foreach (qp[k]) begin
                    if (qp[k] == S - 1)                          moved = ordy;
                    else if (prev_pos == qp[k] + 1)              moved = prev_moved;
                    else                                         moved = 1'b1;
                    if (!(qp[k] == S - 1 && moved)) begin
                        nd.push_back(qd[k]);
                        np.push_back(moved ? qp[k] + 1 : qp[k]);
                    end
                    prev_pos = qp[k]; prev_moved = moved;
                end
                if (iv && exp_ir) begin
                    nd.push_back(ic); np.push_back(0);
                end
                qd = nd; qp = np;
            end
            pend = iv && !exp_ir;
            held = ic;
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
